// File: rtl/decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage: ALU operation codes, base opcodes,
// the registered bundle layout and the funct3 -> ALU operation map.
// Latency: n/a (types and constants only). Backpressure: n/a.
// ALU_ADD is encoded as zero so that a reset or squashed bundle reads back as a harmless ADD.
package decode_stage_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_SLL  = 4'd4;
   localparam logic [3:0] ALU_SRL  = 4'd5;
   localparam logic [3:0] ALU_SRA  = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_XOR  = 4'd9;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;

   localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

   // Decoded instruction as held in the output register.
   typedef struct packed {
      logic [3:0]  alucode;
      logic [31:0] imm;
      logic        using_r2;
      logic        using_pc;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_we;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        is_jump;
      logic [2:0]  funct3;
   } bundle_t;

   // alt selects SUB for funct3=000 and SRA for funct3=101; ignored elsewhere.
   function automatic logic [3:0] alu_map(input logic [2:0] funct3, input logic alt);
      logic [3:0] code;
      case (funct3)
         3'b000:  code = alt ? ALU_SUB : ALU_ADD;
         3'b001:  code = ALU_SLL;
         3'b010:  code = ALU_SLT;
         3'b011:  code = ALU_SLTU;
         3'b100:  code = ALU_XOR;
         3'b101:  code = alt ? ALU_SRA : ALU_SRL;
         3'b110:  code = ALU_OR;
         default: code = ALU_AND;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and bundle signals between fetch, the decode stage and execute.
// Latency: n/a (wiring only). Backpressure: in_valid/in_ready upstream, out_valid/out_ready downstream.
// Modports: master = fetch/execute side (drives in_*, flush, out_ready); slave = decode stage.
// Optional macro ILLEGAL_INSN_EN adds the illegal bundle flag.
interface decode_stage_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_insn;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alucode;
   logic [31:0] imm;
   logic        using_r2;
   logic        using_pc;
   logic [31:0] pc_out;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [4:0]  rd;
   logic        reg_we;
   logic        is_load;
   logic        is_store;
   logic        is_branch;
   logic        is_jump;
   logic [2:0]  funct3;
`ifdef ILLEGAL_INSN_EN
   logic        illegal;
`endif

   modport master (
      output in_valid, in_insn, in_pc, flush, out_ready,
      input  in_ready, out_valid, alucode, imm, using_r2, using_pc, pc_out,
             rs1, rs2, rd, reg_we, is_load, is_store, is_branch, is_jump, funct3
`ifdef ILLEGAL_INSN_EN
      , input illegal
`endif
   );

   modport slave (
      input  in_valid, in_insn, in_pc, flush, out_ready,
      output in_ready, out_valid, alucode, imm, using_r2, using_pc, pc_out,
             rs1, rs2, rd, reg_we, is_load, is_store, is_branch, is_jump, funct3
`ifdef ILLEGAL_INSN_EN
      , output illegal
`endif
   );

endinterface

// File: rtl/decode_stage_imm_gen.sv
// Extracts the I/S/B/U/J immediate of an RV32I instruction, chosen by opcode.
// Latency: combinational. Backpressure: none.
// Ports: insn (instruction word in), imm (sign-extended immediate out, 0 for R-type/unknown).
module decode_stage_imm_gen
   import decode_stage_pkg::*;
(
   input  logic [31:0] insn,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (insn[6:0])
         OPC_OP_IMM: begin
            // funct3 001 (SLLI) and 101 (SRLI/SRAI) share low bits 01: shamt only,
            // so insn[30] (the SRAI select) never leaks into the operand.
            if (insn[13:12] == 2'b01) imm = {27'b0, insn[24:20]};
            else                      imm = {{20{insn[31]}}, insn[31:20]};
         end
         OPC_JALR, OPC_LOAD: imm = {{20{insn[31]}}, insn[31:20]};
         OPC_STORE:          imm = {{20{insn[31]}}, insn[31:25], insn[11:7]};
         OPC_BRANCH:         imm = {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC: imm = {insn[31:12], 12'b0};
         OPC_JAL:            imm = {{11{insn[31]}}, insn[31], insn[19:12], insn[20], insn[30:21], 1'b0};
         default:            imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I decoder: turns an instruction word + PC into the ALU control bundle held in one output register.
// Latency: 1 cycle (accept at edge N, out_valid at N+1); throughput 1/cycle.
// Backpressure: in_ready = !out_valid || out_ready; bundle held stable while stalled; flush wins over accept.
// Ports: clk, rst (async active-high), bus (decode_stage_if.slave: fetch handshake, flush, bundle outputs).
// Optional macro ILLEGAL_INSN_EN: flags unrecognised encodings and freezes the stage until flush.
module decode_stage
   import decode_stage_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   decode_stage_if.slave bus
);

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic [31:0] imm_w;
   bundle_t     dec;
   logic        legal;
   logic        writes_rd;

   assign opc = bus.in_insn[6:0];
   assign f3  = bus.in_insn[14:12];
   assign f7  = bus.in_insn[31:25];

   decode_stage_imm_gen u_imm_gen (
      .insn (bus.in_insn),
      .imm  (imm_w)
   );

   // Class decode of the incoming instruction.
   always_comb begin
      dec          = '0;
      legal        = 1'b0;
      writes_rd    = 1'b0;
      dec.pc       = bus.in_pc;
      dec.funct3   = f3;
      dec.alucode  = ALU_ADD;
      dec.imm      = imm_w;
      dec.rs1      = bus.in_insn[19:15];
      dec.rd       = bus.in_insn[11:7];
      case (opc)
         OPC_OP: begin
            legal        = (f7 == 7'b0) || ((f7 == FUNCT7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            dec.alucode  = alu_map(f3, f7[5]);
            dec.using_r2 = 1'b1;
            dec.rs2      = bus.in_insn[24:20];
            writes_rd    = 1'b1;
         end
         OPC_OP_IMM: begin
            if (f3 == 3'b001)      legal = (f7 == 7'b0);
            else if (f3 == 3'b101) legal = (f7 == 7'b0) || (f7 == FUNCT7_ALT);
            else                   legal = 1'b1;
            // No SUBI: the alt bit only matters for the right shift.
            dec.alucode = alu_map(f3, (f3 == 3'b101) && bus.in_insn[30]);
            writes_rd   = 1'b1;
         end
         OPC_LUI: begin
            legal     = 1'b1;
            dec.rs1   = 5'd0;          // x0 + imm
            writes_rd = 1'b1;
         end
         OPC_AUIPC: begin
            legal        = 1'b1;
            dec.using_pc = 1'b1;
            writes_rd    = 1'b1;
         end
         OPC_JAL: begin
            legal        = 1'b1;
            dec.using_pc = 1'b1;
            dec.is_jump  = 1'b1;
            writes_rd    = 1'b1;
         end
         OPC_JALR: begin
            legal       = (f3 == 3'b000);
            dec.is_jump = 1'b1;
            writes_rd   = 1'b1;
         end
         OPC_BRANCH: begin
            legal         = (f3 != 3'b010) && (f3 != 3'b011);
            dec.using_pc  = 1'b1;      // ALU forms the target; compare is done elsewhere
            dec.is_branch = 1'b1;
            dec.rs2       = bus.in_insn[24:20];
         end
         OPC_LOAD: begin
            legal       = (f3 != 3'b011) && (f3[2:1] != 2'b11);
            dec.is_load = 1'b1;
            writes_rd   = 1'b1;
         end
         OPC_STORE: begin
            legal        = !f3[2] && (f3 != 3'b011);
            dec.is_store = 1'b1;
            dec.rs2      = bus.in_insn[24:20];
         end
         default: legal = 1'b0;
      endcase
      dec.reg_we = writes_rd && (dec.rd != 5'd0);
      // Unrecognised encodings collapse to a no-write ADD bubble.
      if (!legal) begin
         dec        = '0;
         dec.pc     = bus.in_pc;
         dec.funct3 = f3;
      end
   end

   // Output register and handshake.
   bundle_t bundle_q, bundle_d;
   logic    out_valid_q, out_valid_d;
   logic    hold;
   logic    accept;

`ifdef ILLEGAL_INSN_EN
   logic illegal_q, illegal_d;
   // An illegal bundle freezes the stage (not consumable, no new accepts) until a flush redirects fetch.
   assign hold        = out_valid_q && illegal_q;
   assign bus.illegal = illegal_q;
`else
   assign hold = 1'b0;
`endif

   assign bus.in_ready = (!out_valid_q || bus.out_ready) && !hold;
   assign accept       = bus.in_valid && bus.in_ready && !bus.flush;

   always_comb begin
      out_valid_d = out_valid_q;
      bundle_d    = bundle_q;
      if (bus.flush) begin
         out_valid_d = 1'b0;
      end else if (accept) begin
         out_valid_d = 1'b1;
         bundle_d    = dec;
      end else if (bus.out_ready && !hold) begin
         out_valid_d = 1'b0;
      end
   end

`ifdef ILLEGAL_INSN_EN
   always_comb begin
      illegal_d = illegal_q;
      if (accept) illegal_d = !legal;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) illegal_q <= 1'b0;
      else     illegal_q <= illegal_d;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         bundle_q    <= bundle_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.alucode   = bundle_q.alucode;
   assign bus.imm       = bundle_q.imm;
   assign bus.using_r2  = bundle_q.using_r2;
   assign bus.using_pc  = bundle_q.using_pc;
   assign bus.pc_out    = bundle_q.pc;
   assign bus.rs1       = bundle_q.rs1;
   assign bus.rs2       = bundle_q.rs2;
   assign bus.rd        = bundle_q.rd;
   assign bus.reg_we    = bundle_q.reg_we;
   assign bus.is_load   = bundle_q.is_load;
   assign bus.is_store  = bundle_q.is_store;
   assign bus.is_branch = bundle_q.is_branch;
   assign bus.is_jump   = bundle_q.is_jump;
   assign bus.funct3    = bundle_q.funct3;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: vector table, hand-written handshake/flush/illegal/reset sequences,
// then randomized traffic against a transaction-level reference model.
// Honours ILLEGAL_INSN_EN when defined.
module tb_decode_stage;
   import decode_stage_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   decode_stage_if bus();

   decode_stage dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]  alucode;
      logic [31:0] imm;
      logic        using_r2;
      logic        using_pc;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_we;
      logic        is_load;
      logic        is_store;
      logic        is_branch;
      logic        is_jump;
      logic [2:0]  funct3;
      logic        illegal;
   } exp_t;

   typedef struct {
      string       name;
      logic [31:0] insn;
      logic [31:0] pc;
      exp_t        exp;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vq[$];

   function automatic exp_t mk(input logic [3:0] a, input logic [31:0] imm, input logic r2, input logic upc,
                               input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic we, input logic ld, input logic st,
                               input logic br, input logic jp, input logic [2:0] f3);
      exp_t e;
      e.alucode = a;  e.imm = imm;  e.using_r2 = r2;  e.using_pc = upc;  e.pc = pc;
      e.rs1 = rs1;  e.rs2 = rs2;  e.rd = rd;  e.reg_we = we;
      e.is_load = ld;  e.is_store = st;  e.is_branch = br;  e.is_jump = jp;
      e.funct3 = f3;  e.illegal = 1'b0;
      return e;
   endfunction

   function automatic exp_t observed();
      exp_t o;
      o.alucode = bus.alucode;  o.imm = bus.imm;  o.using_r2 = bus.using_r2;  o.using_pc = bus.using_pc;
      o.pc = bus.pc_out;  o.rs1 = bus.rs1;  o.rs2 = bus.rs2;  o.rd = bus.rd;  o.reg_we = bus.reg_we;
      o.is_load = bus.is_load;  o.is_store = bus.is_store;  o.is_branch = bus.is_branch;
      o.is_jump = bus.is_jump;  o.funct3 = bus.funct3;
`ifdef ILLEGAL_INSN_EN
      o.illegal = bus.illegal;
`else
      o.illegal = 1'b0;
`endif
      return o;
   endfunction

   // Reference decode built straight from the RV32I encoding rules.
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
      exp_t e;
      logic [3:0] alu_tbl [8];
      int f3, f7, s, imm_i, imm_s, imm_b, imm_j;
      logic ok, wr;
      alu_tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      f3 = int'(i[14:12]);
      f7 = int'(i[31:25]);
      s  = i;
      imm_i = s >>> 20;
      imm_s = (s >>> 25) * 32 + int'(i[11:7]);
      imm_b = (s >>> 31) * 4096 + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
      imm_j = (s >>> 31) * 1048576 + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
      e = '0;
      e.pc = pc;  e.funct3 = i[14:12];  e.rs1 = i[19:15];  e.rd = i[11:7];  e.alucode = ALU_ADD;
      ok = 1'b0;  wr = 1'b0;
      case (i[6:0])
         7'h33: begin
            ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
            e.alucode = (f7 == 32) ? ((f3 == 0) ? ALU_SUB : ALU_SRA) : alu_tbl[i[14:12]];
            e.using_r2 = 1'b1;  e.rs2 = i[24:20];  wr = 1'b1;
         end
         7'h13: begin
            ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1;
            e.alucode = (f3 == 5 && i[30]) ? ALU_SRA : alu_tbl[i[14:12]];
            e.imm = (f3 == 1 || f3 == 5) ? {27'b0, i[24:20]} : imm_i;
            wr = 1'b1;
         end
         7'h37: begin ok = 1'b1; e.rs1 = 5'd0; e.imm = i & 32'hFFFF_F000; wr = 1'b1; end
         7'h17: begin ok = 1'b1; e.using_pc = 1'b1; e.imm = i & 32'hFFFF_F000; wr = 1'b1; end
         7'h6F: begin ok = 1'b1; e.using_pc = 1'b1; e.imm = imm_j; e.is_jump = 1'b1; wr = 1'b1; end
         7'h67: begin ok = (f3 == 0); e.imm = imm_i; e.is_jump = 1'b1; wr = 1'b1; end
         7'h63: begin
            ok = (f3 != 2 && f3 != 3);
            e.using_pc = 1'b1;  e.imm = imm_b;  e.is_branch = 1'b1;  e.rs2 = i[24:20];
         end
         7'h03: begin ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); e.imm = imm_i; e.is_load = 1'b1; wr = 1'b1; end
         7'h23: begin ok = (f3 <= 2); e.imm = imm_s; e.is_store = 1'b1; e.rs2 = i[24:20]; end
         default: ok = 1'b0;
      endcase
      e.reg_we = wr && (i[11:7] != 5'd0);
      if (!ok) begin
         e = '0;
         e.pc = pc;
         e.funct3 = i[14:12];
`ifdef ILLEGAL_INSN_EN
         e.illegal = 1'b1;
`endif
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                        input logic ordy, input logic fl);
      bus.in_valid  = v;
      bus.in_insn   = insn;
      bus.in_pc     = pc;
      bus.out_ready = ordy;
      bus.flush     = fl;
   endtask

   function automatic logic [31:0] rand_insn();
      logic [6:0]  ops [9];
      logic [31:0] r;
      int sel;
      ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
      r   = $urandom();
      sel = $urandom_range(0, 11);
      if (sel < 9)       return {r[31:7], ops[sel]};
      else if (sel == 9) return {r[31:7], 7'h7F};
      else               return r;
   endfunction

   initial begin
      exp_t zero_b, ex, m_b;
      logic m_valid, m_ready, m_hold;
      logic [31:0] ins_a, ins_b, ins_c;

      zero_b = '0;
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      // Reset state.
      @(negedge clk);
      @(negedge clk);
      chk("reset_out_valid", bus.out_valid, 1'b0);
      chk("reset_in_ready",  bus.in_ready,  1'b1);
      chk("reset_bundle",    observed(),    zero_b);
      rst = 1'b0;
      tick();
      chk("post_reset_bundle", observed(), zero_b);

      // Vector table: name, insn, pc, expected bundle.
      vq.push_back('{"add",     32'h002081B3, 32'h000, mk(ALU_ADD,  32'h0,        1,0, 32'h000, 1,2,3,  1,0,0,0,0, 3'd0)});
      vq.push_back('{"srai",    32'h40735293, 32'h004, mk(ALU_SRA,  32'h7,        0,0, 32'h004, 6,0,5,  1,0,0,0,0, 3'd5)});
      vq.push_back('{"srli",    32'h00735293, 32'h008, mk(ALU_SRL,  32'h7,        0,0, 32'h008, 6,0,5,  1,0,0,0,0, 3'd5)});
      vq.push_back('{"beq",     32'hFE000EE3, 32'h100, mk(ALU_ADD,  32'hFFFFFFFC, 0,1, 32'h100, 0,0,29, 0,0,0,1,0, 3'd0)});
      vq.push_back('{"lui",     32'h123453B7, 32'h104, mk(ALU_ADD,  32'h12345000, 0,0, 32'h104, 0,0,7,  1,0,0,0,0, 3'd5)});
      vq.push_back('{"jal",     32'h008000EF, 32'h108, mk(ALU_ADD,  32'h8,        0,1, 32'h108, 0,0,1,  1,0,0,0,1, 3'd0)});
      vq.push_back('{"sw",      32'h00512623, 32'h10C, mk(ALU_ADD,  32'hC,        0,0, 32'h10C, 2,5,12, 0,0,1,0,0, 3'd2)});
      vq.push_back('{"lw",      32'hFF852303, 32'h110, mk(ALU_ADD,  32'hFFFFFFF8, 0,0, 32'h110, 10,0,6, 1,1,0,0,0, 3'd2)});
      vq.push_back('{"add_x0",  32'h00208033, 32'h114, mk(ALU_ADD,  32'h0,        1,0, 32'h114, 1,2,0,  0,0,0,0,0, 3'd0)});
      vq.push_back('{"jalr",    32'h004280E7, 32'h118, mk(ALU_ADD,  32'h4,        0,0, 32'h118, 5,0,1,  1,0,0,0,1, 3'd0)});
      vq.push_back('{"sub",     32'h402081B3, 32'h11C, mk(ALU_SUB,  32'h0,        1,0, 32'h11C, 1,2,3,  1,0,0,0,0, 3'd0)});
      vq.push_back('{"slti",    32'hFFF0A213, 32'h120, mk(ALU_SLT,  32'hFFFFFFFF, 0,0, 32'h120, 1,0,4,  1,0,0,0,0, 3'd2)});
      vq.push_back('{"xor",     32'h003140B3, 32'h124, mk(ALU_XOR,  32'h0,        1,0, 32'h124, 2,3,1,  1,0,0,0,0, 3'd4)});

      // Back-to-back application, one instruction per cycle.
      foreach (vq[k]) begin
         drive(1'b1, vq[k].insn, vq[k].pc, 1'b1, 1'b0);
         if (k == 0) begin
            #1;
            chk("latency_not_before_edge", bus.out_valid, 1'b0);
         end
         tick();
         chk({vq[k].name, "_valid"},  bus.out_valid, 1'b1);
         chk({vq[k].name, "_bundle"}, observed(),    vq[k].exp);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("drain_valid", bus.out_valid, 1'b0);

      // Backpressure: stall 3 cycles with a new instruction waiting, then release.
      ins_a = 32'h002081B3;
      ins_b = 32'h402081B3;
      drive(1'b1, ins_a, 32'h200, 1'b1, 1'b0);
      tick();
      drive(1'b1, ins_b, 32'h204, 1'b0, 1'b0);
      #1;
      chk("stall_in_ready", bus.in_ready, 1'b0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("stall_hold_ready",  bus.in_ready,  1'b0);
         chk("stall_hold_valid",  bus.out_valid, 1'b1);
         chk("stall_hold_bundle", observed(),    model(ins_a, 32'h200));
      end
      bus.out_ready = 1'b1;
      #1;
      chk("release_in_ready", bus.in_ready, 1'b1);
      tick();
      chk("release_next_bundle", observed(), model(ins_b, 32'h204));

      // Flush with a held bundle and a new instruction offered.
      ins_c = 32'h003140B3;
      drive(1'b1, ins_c, 32'h208, 1'b0, 1'b1);
      tick();
      chk("flush_clears_valid", bus.out_valid, 1'b0);
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      chk("flush_insn_dropped", bus.out_valid, 1'b0);

      // Unrecognised opcode 0x7F.
      drive(1'b1, 32'h0000007F, 32'h300, 1'b1, 1'b0);
      tick();
      bus.in_insn = ins_a;
      bus.in_pc   = 32'h304;
      #1;
`ifdef ILLEGAL_INSN_EN
      ex = mk(ALU_ADD, 32'h0, 0,0, 32'h300, 0,0,0, 0,0,0,0,0, 3'd0);
      ex.illegal = 1'b1;
      chk("illegal_bundle", observed(), ex);
      chk("illegal_in_ready", bus.in_ready, 1'b0);
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("illegal_frozen_valid", bus.out_valid, 1'b1);
         chk("illegal_frozen_ready", bus.in_ready,  1'b0);
         chk("illegal_frozen_pc",    bus.pc_out,    32'h300);
      end
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      tick();
      bus.flush = 1'b0;
      #1;
      chk("illegal_flush_valid", bus.out_valid, 1'b0);
      chk("illegal_flush_ready", bus.in_ready,  1'b1);
`else
      ex = mk(ALU_ADD, 32'h0, 0,0, 32'h300, 0,0,0, 0,0,0,0,0, 3'd0);
      chk("unknown_bubble", observed(), ex);
      chk("unknown_valid",  bus.out_valid, 1'b1);
      chk("unknown_ready",  bus.in_ready,  1'b1);
      bus.in_valid = 1'b0;
      tick();
`endif

      // Reset in the middle of a stalled transfer.
      drive(1'b1, ins_a, 32'h400, 1'b0, 1'b0);
      tick();
      chk("pre_reset_valid", bus.out_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk("midreset_valid",  bus.out_valid, 1'b0);
      chk("midreset_bundle", observed(),    zero_b);
      chk("midreset_ready",  bus.in_ready,  1'b1);
      @(negedge clk);
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();

      // Randomized traffic against a one-slot transaction model.
      m_valid = 1'b0;
      m_b     = '0;
      for (int n = 0; n < 600; n++) begin
         drive($urandom_range(0, 3) != 0, rand_insn(), $urandom() & 32'hFFFF_FFFC,
               $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
         #1;
`ifdef ILLEGAL_INSN_EN
         m_hold = m_valid && m_b.illegal;
`else
         m_hold = 1'b0;
`endif
         m_ready = (!m_valid || bus.out_ready) && !m_hold;
         chk("rand_in_ready",  bus.in_ready,  m_ready);
         chk("rand_out_valid", bus.out_valid, m_valid);
         if (m_valid) chk("rand_bundle", observed(), m_b);
         if (bus.flush) begin
            m_valid = 1'b0;
         end else if (bus.in_valid && m_ready) begin
            m_valid = 1'b1;
            m_b     = model(bus.in_insn, bus.in_pc);
         end else if (bus.out_ready && !m_hold) begin
            m_valid = 1'b0;
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

endmodule
